// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage RISC-V pipeline.
// It drives the next-PC select, the pipeline-register enables and flushes,
// and the EX-stage forwarding selects. A three-state stall FSM handles the
// load-use bubble and the data-memory wait. Two saturating counters record
// stall cycles and branch flushes.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic             memread_ex,
    input  logic [4:0]       rd_mem,
    input  logic             regwrite_mem,
    input  logic [4:0]       rd_wb,
    input  logic             regwrite_wb,
    input  logic             branch_taken_ex,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_src,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] LU_BUBBLE = 2'd1;
    localparam logic [1:0] MEM_WAIT  = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] state;
    logic [1:0] state_nxt;

    logic       lu_hz;
    logic       mw_hz;
    logic       mem_stall;
    logic       branch_flush;

    logic       mem_hit_a;
    logic       wb_hit_a;
    logic       mem_hit_b;
    logic       wb_hit_b;

    // Producer matches for the EX-stage operands; register x0 never forwards.
    always_comb begin
        mem_hit_a = regwrite_mem && (rd_mem != 5'd0) && (rd_mem == rs1_ex);
        wb_hit_a  = regwrite_wb  && (rd_wb  != 5'd0) && (rd_wb  == rs1_ex);
        mem_hit_b = regwrite_mem && (rd_mem != 5'd0) && (rd_mem == rs2_ex);
        wb_hit_b  = regwrite_wb  && (rd_wb  != 5'd0) && (rd_wb  == rs2_ex);
    end

    // Forwarding selects: the younger EX/MEM result wins over MEM/WB; held at regfile in reset.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (rst) begin
            if (mem_hit_a) begin
                fwd_a = FWD_MEM;
            end else if (wb_hit_a) begin
                fwd_a = FWD_WB;
            end
            if (mem_hit_b) begin
                fwd_b = FWD_MEM;
            end else if (wb_hit_b) begin
                fwd_b = FWD_WB;
            end
        end
    end

    // Hazard detection: load-use against the ID operands, and a pending data-memory access.
    always_comb begin
        lu_hz = memread_ex && (rd_ex != 5'd0) &&
                ((rs1_used && (rd_ex == rs1_id)) || (rs2_used && (rd_ex == rs2_id)));
        mw_hz = mem_req && !mem_ready;
    end

    // While waiting on memory, the stall is released only by mem_ready.
    always_comb begin
        if (state == MEM_WAIT) begin
            mem_stall = !mem_ready;
        end else begin
            mem_stall = mw_hz;
        end
    end

    // Next state and control outputs. LU_BUBBLE and a MEM_WAIT cycle that completes
    // the access follow the RUN rules.
    always_comb begin
        state_nxt    = state;
        pc_src       = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        branch_flush = 1'b0;

        if (!rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = RUN;
        end else if (mem_stall) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            state_nxt = MEM_WAIT;
        end else if (branch_taken_ex) begin
            // The ID instruction is squashed, so a concurrent load-use hazard is ignored.
            pc_src       = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            branch_flush = 1'b1;
            state_nxt    = RUN;
        end else if (lu_hz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_nxt  = LU_BUBBLE;
        end else begin
            state_nxt = RUN;
        end
    end

    // State register; reset aborts any bubble or memory wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Stall-cycle counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Branch-flush counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flush_cnt <= '0;
        end else if (branch_flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with hand-computed directed vectors.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       rs1_used, rs2_used, memread_ex, regwrite_mem, regwrite_wb;
    logic       branch_taken_ex, mem_req, mem_ready;
    logic       pc_src, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .memread_ex(memread_ex),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .branch_taken_ex(branch_taken_ex), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_src(pc_src), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Packed view: {pc_src, en[4:0] = pc/ifid/idex/exmem/memwb, flush[1:0] = ifid/idex, fwd_a, fwd_b, stall_cnt, flush_cnt}
    typedef struct {
        string       name;
        logic [19:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: on each falling edge, compare outputs against the oldest expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [19:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_src, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, fwd_a, fwd_b, stall_cnt, flush_cnt};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s: got %b expected %b (pcsrc|en|fl|fa|fb|sc|fc) t=%0t",
                         e.name, act, e.vec, $time);
            end
        end
    end

    task automatic clear_inputs();
        rs1_id = 5'd0; rs2_id = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        rs1_ex = 5'd0; rs2_ex = 5'd0; rd_ex = 5'd0; memread_ex = 1'b0;
        rd_mem = 5'd0; regwrite_mem = 1'b0; rd_wb = 5'd0; regwrite_wb = 1'b0;
        branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Record the expected response to the inputs just applied, then advance one cycle.
    task automatic expect_vec(input string name, input logic ps, input logic [4:0] en,
                              input logic [1:0] fl, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [3:0] sc, input logic [3:0] fc);
        exp_t e;
        e.name = name;
        e.vec  = {ps, en, fl, fa, fb, sc, fc};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name, input logic [3:0] sc, input logic [3:0] fc);
        expect_vec(name, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00, sc, fc);
    endtask

    // One reset cycle: counters still show their old values until the edge.
    task automatic do_reset(input string name, input logic [3:0] sc, input logic [3:0] fc);
        rst = 1'b0;
        expect_vec(name, 1'b0, 5'b00000, 2'b11, 2'b00, 2'b00, sc, fc);
        rst = 1'b1;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;

        // Reset held for three cycles, then released into RUN
        for (int i = 0; i < 3; i++) begin
            expect_vec("reset_hold", 1'b0, 5'b00000, 2'b11, 2'b00, 2'b00, 4'd0, 4'd0);
        end
        rst = 1'b1;
        idle("reset_release", 4'd0, 4'd0);
        idle("reset_idle", 4'd0, 4'd0);

        // Load-use on rs1
        memread_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used = 1'b1;
        expect_vec("lu_rs1_stall", 1'b0, 5'b00111, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0);
        clear_inputs();
        idle("lu_bubble_release", 4'd1, 4'd0);
        idle("lu_after", 4'd1, 4'd0);
        // x0 destination never causes a load-use stall
        memread_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs1_used = 1'b1;
        idle("lu_x0_none", 4'd1, 4'd0);
        // Match on rs2 that the ID instruction does not read
        memread_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd3; rs1_used = 1'b1;
        rs2_id = 5'd5; rs2_used = 1'b0;
        idle("lu_rs2_unused", 4'd1, 4'd0);
        rs2_used = 1'b1;
        expect_vec("lu_rs2_stall", 1'b0, 5'b00111, 2'b01, 2'b00, 2'b00, 4'd1, 4'd0);
        clear_inputs();
        idle("lu_rs2_release", 4'd2, 4'd0);
        do_reset("reset_after_lu", 4'd2, 4'd0);
        idle("cnt_cleared_lu", 4'd0, 4'd0);

        // Branch taken together with a load-use hazard
        memread_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used = 1'b1; branch_taken_ex = 1'b1;
        expect_vec("branch_over_lu", 1'b1, 5'b11111, 2'b11, 2'b00, 2'b00, 4'd0, 4'd0);
        clear_inputs();
        idle("branch_after", 4'd0, 4'd1);
        do_reset("reset_after_br", 4'd0, 4'd1);
        idle("cnt_cleared_br", 4'd0, 4'd0);

        // Data-memory wait for four cycles, branch pulsed mid-wait
        mem_req = 1'b1; mem_ready = 1'b0;
        expect_vec("mw_c1", 1'b0, 5'b00000, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0);
        expect_vec("mw_c2", 1'b0, 5'b00000, 2'b00, 2'b00, 2'b00, 4'd1, 4'd0);
        branch_taken_ex = 1'b1;
        expect_vec("mw_branch_masked", 1'b0, 5'b00000, 2'b00, 2'b00, 2'b00, 4'd2, 4'd0);
        branch_taken_ex = 1'b0;
        expect_vec("mw_c4", 1'b0, 5'b00000, 2'b00, 2'b00, 2'b00, 4'd3, 4'd0);
        mem_ready = 1'b1;
        idle("mw_ready", 4'd4, 4'd0);
        clear_inputs();
        idle("mw_after", 4'd4, 4'd0);
        do_reset("reset_after_mw", 4'd4, 4'd0);
        idle("cnt_cleared_mw", 4'd0, 4'd0);

        // Forwarding priority and x0 handling
        rs1_ex = 5'd7; rd_mem = 5'd7; regwrite_mem = 1'b1; rd_wb = 5'd7; regwrite_wb = 1'b1;
        expect_vec("fwd_a_mem_wins", 1'b0, 5'b11111, 2'b00, 2'b10, 2'b00, 4'd0, 4'd0);
        rd_mem = 5'd0;
        expect_vec("fwd_a_wb", 1'b0, 5'b11111, 2'b00, 2'b01, 2'b00, 4'd0, 4'd0);
        rd_wb = 5'd0;
        idle("fwd_x0_none", 4'd0, 4'd0);
        rs1_ex = 5'd3; rs2_ex = 5'd9; rd_mem = 5'd9; regwrite_mem = 1'b0;
        rd_wb = 5'd9; regwrite_wb = 1'b1;
        expect_vec("fwd_b_wb", 1'b0, 5'b11111, 2'b00, 2'b00, 2'b01, 4'd0, 4'd0);
        regwrite_mem = 1'b1;
        expect_vec("fwd_b_mem", 1'b0, 5'b11111, 2'b00, 2'b00, 2'b10, 4'd0, 4'd0);
        do_reset("fwd_in_reset", 4'd0, 4'd0);
        idle("fwd_cleared", 4'd0, 4'd0);

        // Long memory wait saturates the 4-bit stall counter, then reset aborts the wait
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            expect_vec("stall_sat", 1'b0, 5'b00000, 2'b00, 2'b00, 2'b00,
                       (k > 15) ? 4'd15 : 4'(k), 4'd0);
        end
        rst = 1'b0;
        expect_vec("reset_mid_wait", 1'b0, 5'b00000, 2'b11, 2'b00, 2'b00, 4'd15, 4'd0);
        rst = 1'b1;
        clear_inputs();
        idle("run_after_abort", 4'd0, 4'd0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
